// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: aligns stores, extends loads, runs the
// req/gnt/rvalid handshake and presents a registered writeback bundle.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rd_addr_i,
  input  logic                  reg_write_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [4:0]            wb_rd_addr_o,
  output logic                  wb_reg_write_o,
  output logic                  fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;

  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic [4:0]            rd_q;
  logic                  rw_q;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [1:0]            a;
  logic                  is_mem, bad_f3, misaligned, fault_det;
  logic [3:0]            be_n;
  logic [31:0]           sdata32, rdata32, wdata_n, load_val;
  logic [7:0]            lb;
  logic [15:0]           lh;

  assign eff_addr = ADDR_WIDTH'(alu_result_i);
  assign sdata32  = 32'(store_data_i);
  assign rdata32  = 32'(dmem_rdata_i);
  assign stall_o  = (state != IDLE);

  always_comb begin
    a          = eff_addr[1:0];
    is_mem     = mem_read_i | mem_write_i;
    bad_f3     = 1'b0;
    case (funct3_i)
      3'b011, 3'b110, 3'b111: bad_f3 = 1'b1;
      default:                bad_f3 = 1'b0;
    endcase
    misaligned = ((funct3_i[1:0] == 2'b01) && a[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (a != 2'b00));
    fault_det  = is_mem && (bad_f3 || (mem_read_i && mem_write_i) || misaligned);
    case (funct3_i[1:0])
      2'b00: begin
        be_n    = 4'b0001 << a;
        wdata_n = {4{sdata32[7:0]}};
      end
      2'b01: begin
        be_n    = a[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{sdata32[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = sdata32;
      end
    endcase
  end

  always_comb begin
    lb       = 8'(rdata32 >> {lane_q, 3'b000});
    lh       = 16'(rdata32 >> {lane_q[1], 4'b0000});
    load_val = rdata32;
    case (f3_q)
      3'b000:  load_val = {{24{lb[7]}}, lb};
      3'b001:  load_val = {{16{lh[15]}}, lh};
      3'b100:  load_val = {24'h0, lb};
      3'b101:  load_val = {16'h0, lh};
      default: load_val = rdata32;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_rd_addr_o   <= '0;
      wb_reg_write_o <= 1'b0;
      fault_o        <= 1'b0;
      f3_q           <= '0;
      lane_q         <= '0;
      rd_q           <= '0;
      rw_q           <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      fault_o    <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          if (!is_mem) begin
            wb_valid_o     <= 1'b1;
            wb_data_o      <= alu_result_i;
            wb_rd_addr_o   <= rd_addr_i;
            wb_reg_write_o <= reg_write_i;
          end else if (fault_det) begin
            fault_o <= 1'b1;
          end else begin
            state        <= REQ;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_write_i;
            dmem_addr_o  <= {eff_addr[ADDR_WIDTH-1:2], 2'b00};
            dmem_be_o    <= be_n;
            dmem_wdata_o <= DATA_WIDTH'(wdata_n);
            f3_q         <= funct3_i;
            lane_q       <= a;
            rd_q         <= rd_addr_i;
            rw_q         <= reg_write_i;
          end
        end
        REQ: if (dmem_gnt_i) begin
          dmem_req_o <= 1'b0;
          if (dmem_we_o) begin
            state          <= IDLE;
            wb_valid_o     <= 1'b1;
            wb_rd_addr_o   <= rd_q;
            wb_reg_write_o <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dmem_rvalid_i) begin
          state          <= IDLE;
          wb_valid_o     <= 1'b1;
          wb_data_o      <= DATA_WIDTH'(load_val);
          wb_rd_addr_o   <= rd_q;
          wb_reg_write_o <= rw_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
